// File: rtl/preset_sequencer.sv
// Footswitch preset controller: recalls stored MIDI messages onto a valid/ready
// byte stream, or stores the most recently captured channel message into a slot.
module preset_sequencer #(
    parameter int unsigned ACK_HOLD_CNT = 24_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_index,
    input  logic       save_mode,
    input  logic       in_msg_valid,
    input  logic [7:0] in_status,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [2:0] active_slot,
    output logic       save_led,
    output logic       save_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  last_idx_q;
    logic [7:0]  msg0_q, msg1_q, msg2_q;

    logic [7:0]  slot_status_q [4];
    logic [7:0]  slot_data1_q  [4];
    logic [7:0]  slot_data2_q  [4];

    logic        cap_valid_q;
    logic [7:0]  cap_status_q, cap_data1_q, cap_data2_q;

    logic [2:0]  active_slot_q;
    logic [31:0] led_cnt_q, led_cnt_d;
    logic        save_err_q;

    logic        btn_event;
    logic [1:0]  slot_idx;
    logic        in_idle;
    logic        recall_ev;
    logic        save_req;
    logic        save_ok;
    logic        cap_load;
    logic        xfer;
    logic [7:0]  sel_status;

    // Decode the button event; only honoured while idle.
    always_comb begin
        btn_event  = (btn_index >= 3'd1) && (btn_index <= 3'd4);
        slot_idx   = btn_index[1:0] - 2'd1;
        in_idle    = (state_q == StIdle);
        recall_ev  = in_idle && btn_event && !save_mode;
        save_req   = in_idle && btn_event && save_mode;
        save_ok    = save_req && cap_valid_q;
        // Only channel messages (not system 0xF_) are worth storing.
        cap_load   = in_msg_valid && in_status[7] && (in_status[7:4] != 4'hF);
        xfer       = tx_valid && tx_ready;
        sel_status = slot_status_q[slot_idx];
    end

    // FSM and byte counter next state.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            StIdle: begin
                if (recall_ev) begin
                    state_d    = StSend;
                    byte_cnt_d = 2'd0;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (byte_cnt_q == last_idx_q) begin
                        state_d = StDone;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // LED hold timer: reload on a successful save, otherwise count down to zero.
    always_comb begin
        led_cnt_d = led_cnt_q;
        if (save_ok) begin
            led_cnt_d = 32'(ACK_HOLD_CNT);
        end else if (led_cnt_q != 32'd0) begin
            led_cnt_d = led_cnt_q - 32'd1;
        end
    end

    // FSM, counter, message shift register and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 2'd0;
            last_idx_q    <= 2'd0;
            msg0_q        <= 8'h00;
            msg1_q        <= 8'h00;
            msg2_q        <= 8'h00;
            active_slot_q <= 3'd0;
            led_cnt_q     <= 32'd0;
            save_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            led_cnt_q  <= led_cnt_d;
            save_err_q <= save_req && !cap_valid_q;
            if (recall_ev) begin
                msg0_q <= sel_status;
                msg1_q <= slot_data1_q[slot_idx];
                msg2_q <= slot_data2_q[slot_idx];
                // Program Change and Channel Pressure carry a single data byte.
                last_idx_q <= ((sel_status[7:4] == 4'hC) || (sel_status[7:4] == 4'hD)) ?
                              2'd1 : 2'd2;
            end
            if (recall_ev || save_ok) begin
                active_slot_q <= btn_index;
            end
        end
    end

    // Slot memory: defaults are Program Change ch1, programs 0..3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                slot_status_q[i] <= 8'hC0;
                slot_data1_q[i]  <= 8'(i);
                slot_data2_q[i]  <= 8'h00;
            end
        end else if (save_ok) begin
            // Uses the pre-update capture, so a same-cycle message lands next cycle.
            slot_status_q[slot_idx] <= cap_status_q;
            slot_data1_q[slot_idx]  <= cap_data1_q;
            slot_data2_q[slot_idx]  <= cap_data2_q;
        end
    end

    // Last-message capture, active in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid_q  <= 1'b0;
            cap_status_q <= 8'h00;
            cap_data1_q  <= 8'h00;
            cap_data2_q  <= 8'h00;
        end else if (cap_load) begin
            cap_valid_q  <= 1'b1;
            cap_status_q <= in_status;
            cap_data1_q  <= in_data1;
            cap_data2_q  <= in_data2;
        end
    end

    // Outputs are decoded from registers only; tx_valid never sees tx_ready.
    always_comb begin
        tx_valid    = (state_q == StSend);
        busy        = (state_q != StIdle);
        active_slot = active_slot_q;
        save_led    = (led_cnt_q != 32'd0);
        save_err    = save_err_q;
        tx_data     = 8'h00;
        if (state_q == StSend) begin
            case (byte_cnt_q)
                2'd0:    tx_data = msg0_q;
                2'd1:    tx_data = msg1_q;
                default: tx_data = msg2_q;
            endcase
        end
    end

endmodule

// File: tb/tb_preset_sequencer.sv
// Directed bench for preset_sequencer: a per-cycle vector table followed by
// hand-written recall, stall, drop, same-cycle and mid-transfer reset sequences.
module tb_preset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn_index = 3'd0;
    logic       save_mode = 1'b0;
    logic       in_msg_valid = 1'b0;
    logic [7:0] in_status = 8'h00;
    logic [7:0] in_data1 = 8'h00;
    logic [7:0] in_data2 = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic [2:0] active_slot;
    logic       save_led;
    logic       save_err;

    int n_total = 0;
    int n_pass  = 0;

    preset_sequencer #(.ACK_HOLD_CNT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_index    (btn_index),
        .save_mode    (save_mode),
        .in_msg_valid (in_msg_valid),
        .in_status    (in_status),
        .in_data1     (in_data1),
        .in_data2     (in_data2),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .active_slot  (active_slot),
        .save_led     (save_led),
        .save_err     (save_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;
        logic       save;
        logic       mv;
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic [2:0] e_slot;
        logic       e_led;
        logic       e_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        btn_index = 3'd0; save_mode = 1'b0; in_msg_valid = 1'b0;
        in_status = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00;
    endtask

    // Recall a slot and collect the streamed bytes. mode 0: ready tied high;
    // mode 1: ready high one cycle in three. inject presses other buttons mid-send.
    task automatic do_recall(input logic [2:0] slot, input int mode, input bit inject,
                             input int elen, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
        logic [7:0] got [4];
        logic [7:0] exp_b [3];
        int   n = 0;
        int   cyc = 0;
        bit   done = 0;
        bit   pv = 0, px = 0, rdy;
        logic [7:0] pd = 8'h00;
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
        clear_inputs();
        btn_index = slot; tx_ready = 1'b0;
        @(negedge clk);
        btn_index = 3'd0;
        check("recall_busy_start", busy, 1);
        check("recall_first_byte", tx_data, e0);
        while (!done && cyc < 200) begin
            if (tx_valid && pv && !px) check("stall_data_stable", tx_data, pd);
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            btn_index = 3'd0; save_mode = 1'b0;
            if (inject && cyc == 0) begin btn_index = 3'd1; save_mode = 1'b0; end
            if (inject && cyc == 1) begin btn_index = 3'd2; save_mode = 1'b1; end
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                if (n < 4) got[n] = tx_data;
                n++;
            end
            pv = tx_valid; px = tx_valid && rdy; pd = tx_data;
            if (!busy) done = 1;
            @(negedge clk);
            cyc++;
        end
        clear_inputs();
        tx_ready = 1'b0;
        check("recall_completes", int'(done), 1);
        check("recall_len", n, elen);
        for (int i = 0; i < elen && i < n && i < 3; i++) check("recall_byte", got[i], exp_b[i]);
        check("recall_active_slot", active_slot, slot);
    endtask

    initial begin
        // Cycle-by-cycle table right after reset.
        vecs[0]  = '{3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hC0, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1};
        vecs[5]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{3'd0, 1'b0, 1'b1, 8'h90, 8'h3C, 8'h64, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0};
        for (int i = 8; i < 15; i++)
            vecs[i] = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0};
        vecs[15] = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_active_slot", active_slot, 0);
        check("rst_save_led", save_led, 0);
        check("rst_save_err", save_err, 0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            btn_index = vecs[i].btn; save_mode = vecs[i].save; in_msg_valid = vecs[i].mv;
            in_status = vecs[i].st; in_data1 = vecs[i].d1; in_data2 = vecs[i].d2;
            tx_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_active_slot", i), active_slot, vecs[i].e_slot);
            check($sformatf("vec%0d_save_led", i), save_led, vecs[i].e_led);
            check($sformatf("vec%0d_save_err", i), save_err, vecs[i].e_err);
        end
        clear_inputs();
        tx_ready = 1'b0;

        // Failed save left slot 1 at its default.
        do_recall(3'd1, 0, 1'b0, 2, 8'hC0, 8'h00, 8'h00);
        // Saved message with a 1-of-3 ready pattern.
        do_recall(3'd3, 1, 1'b0, 3, 8'h90, 8'h3C, 8'h64);
        // Presses during a recall are dropped, including a save.
        do_recall(3'd4, 1, 1'b1, 2, 8'hC0, 8'h03, 8'h00);
        check("dropped_save_led", save_led, 0);
        do_recall(3'd2, 0, 1'b0, 2, 8'hC0, 8'h01, 8'h00);

        // Same-cycle capture and save: the save takes the older capture.
        in_msg_valid = 1'b1; in_status = 8'hC0; in_data1 = 8'h05; in_data2 = 8'h00;
        @(negedge clk);
        in_status = 8'hB0; in_data1 = 8'h07; in_data2 = 8'h7F;
        btn_index = 3'd1; save_mode = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("samecycle_active_slot", active_slot, 1);
        check("samecycle_save_led", save_led, 1);
        check("samecycle_save_err", save_err, 0);
        do_recall(3'd1, 0, 1'b0, 2, 8'hC0, 8'h05, 8'h00);

        // System realtime byte must not replace the capture.
        in_msg_valid = 1'b1; in_status = 8'hF8; in_data1 = 8'h11; in_data2 = 8'h22;
        @(negedge clk);
        clear_inputs();
        btn_index = 3'd2; save_mode = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("save2_err", save_err, 0);
        do_recall(3'd2, 0, 1'b0, 3, 8'hB0, 8'h07, 8'h7F);

        // Mid-transfer asynchronous reset.
        btn_index = 3'd3;
        @(negedge clk);
        btn_index = 3'd0;
        tx_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_second_byte", tx_data, 8'h3C);
        check("pre_rst_tx_valid", tx_valid, 1);
        tx_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx_valid", tx_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_active_slot", active_slot, 0);
        @(negedge clk);
        rst = 1'b1;
        do_recall(3'd3, 0, 1'b0, 2, 8'hC0, 8'h02, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/preset_sequencer.md
# preset_sequencer

Footswitch preset controller between the button decoder and the MIDI output UART. It consumes the decoder's one-cycle `btn_index`/`save_mode` event and either recalls a stored preset or stores the last captured incoming MIDI channel message into the pressed slot. A recall streams the slot's message over a valid/ready byte interface to the MIDI transmitter. The block holds four slots, a last-message capture register and a save-confirmation LED timer.

## Interface
- `ACK_HOLD_CNT`, default 24_000_000: clock cycles `save_led` stays high after a successful save.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_index`  in  3  event from the button decoder: 0 = none, 1..4 = slot pressed (one cycle wide); 5..7 are treated as none.
- `save_mode`  in  1  qualifies `btn_index`: 1 = save, 0 = recall.
- `in_msg_valid`  in  1  one-cycle strobe: a complete MIDI message was parsed.
- `in_status`, `in_data1`, `in_data2`  in  8 each  parsed message bytes, valid with `in_msg_valid`.
- `tx_valid`  out  1  byte available to the transmitter.
- `tx_data`  out  8  byte to send.
- `tx_ready`  in  1  transmitter accepts the byte.
- `busy`  out  1  recall in progress.
- `active_slot`  out  3  last recalled or saved slot (0 = none).
- `save_led`  out  1  save confirmation.
- `save_err`  out  1  one-cycle pulse: save requested with no captured message.

## Operation
- Slot memory: 4 × {status, data1, data2}. Reset contents: slot n = {0xC0, n-1, 0x00}, i.e. Program Change channel 1, program 0..3.
- Capture register: {valid, status, data1, data2}. It loads on `in_msg_valid` only when `in_status[7]`=1 and `in_status[7:4]`≠0xF. Other messages are ignored. Reset `valid`=0.
- Message length: `status[7:4]` ∈ {0xC, 0xD} → 2 bytes. Any other channel status → 3 bytes.
- FSM states: IDLE, SEND, DONE.
- IDLE, with a recall event (`btn_index` 1..4, `save_mode`=0):
  - latch the slot into the output shift register;
  - set `active_slot`=`btn_index` and byte counter=0;
  - go to SEND.
- IDLE, with a save event (`save_mode`=1):
  - If capture `valid`=1: write the capture register into the slot, set `active_slot`=`btn_index`, load the LED timer with ACK_HOLD_CNT, and stay in IDLE.
  - If capture `valid`=0: pulse `save_err` for one cycle. Slot memory and `active_slot` are unchanged.
- SEND:
  - `tx_valid`=1 and `tx_data`=current byte.
  - On `tx_valid && tx_ready`, advance the counter.
  - After the last byte is accepted, go to DONE.
  - `tx_valid` never depends combinationally on `tx_ready`. `tx_data` is stable while `tx_valid`=1 and no transfer has occurred.
- DONE: one cycle, `tx_valid`=0, then return to IDLE.
- `busy`=1 in SEND and DONE.
- All button events outside IDLE are dropped, with no queuing. This includes a save event.
- Capture continues in every state.
- If a save and a capture land in the same cycle, the save writes the pre-update capture contents. The new message is visible from the next cycle.
- LED timer: `save_led`=1 while the counter is nonzero; it decrements every cycle. A new successful save reloads it to ACK_HOLD_CNT.
- Asserting `rst` mid-SEND aborts the transfer immediately. `tx_valid` drops asynchronously and the slots return to their defaults.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `active_slot`=0, `save_led`=0, `save_err`=0; FSM in IDLE; LED counter 0.
- Recall event sampled at edge N:
  - at N+1: `busy`=1, `tx_valid`=1, `tx_data`=status byte;
  - each byte is held until the edge where `tx_ready`=1;
  - the next byte appears in the cycle after that edge.
- With `tx_ready` tied high: 2-byte message → `tx_valid` high for 2 cycles; 3-byte message → 3 cycles. DONE follows, and `busy` falls 1 cycle after the last transfer edge.
- Save event at edge N: slot write and `active_slot` update visible at N+1; `save_led` rises at N+1; `save_err` pulses at N+1 for exactly one cycle.
- The earliest accepted next event is the first cycle in IDLE after DONE.

## Test plan
- Reset, then `btn_index`=2 with `save_mode`=0, `tx_ready`=1 → bytes 0xC0, 0x01; `active_slot`=2; `busy` high for 3 cycles.
- Capture {0x90,0x3C,0x64}, save to slot 3, then recall 3 with `tx_ready` toggling 1-of-3 cycles → bytes 0x90, 0x3C, 0x64 in order; `tx_data` stable across stalls; `save_led` high for ACK_HOLD_CNT cycles (bench uses ACK_HOLD_CNT=8).
- Save to slot 1 immediately after reset → `save_err` one-cycle pulse; a later recall of 1 sends 0xC0, 0x00.
- During a recall of slot 4, press `btn_index`=1 (recall) and 2 (save) → both ignored; only slot 4 bytes are sent; `active_slot` stays 4.
- Same-cycle `in_msg_valid` {0xB0,0x07,0x7F} and save to slot 1, with prior capture {0xC0,0x05} → slot 1 recall sends 0xC0, 0x05. A 0xF8 capture afterward is ignored.
- Drive `rst` low while the second byte is pending → `tx_valid`=0 without waiting for a clock edge; after release, recall of slot 3 sends 0xC0, 0x02.
